// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, majority vote per bit,
// valid/ready output holding register with overrun and framing flags.
module uart_rx #(
    parameter int CLK_FREQ = 65_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int OVS_DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int CW      = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [CW-1:0] OVS_MAX = CW'(OVS_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_next;
    logic          rx_s1;
    logic          rx_s2;
    logic [CW-1:0] ovs_cnt;
    logic          tick;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          s7;
    logic          s8;
    logic          vote;
    logic          armed;
    logic          at_t9;
    logic          at_t15;
    logic          enter;
    logic          sample_bit;
    logic          stop_done;
    logic          stop_ok;
    logic          stop_bad;
    logic          load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= RxD;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovs_cnt <= '0;
        end else if (ovs_cnt == OVS_MAX) begin
            ovs_cnt <= '0;
        end else begin
            ovs_cnt <= ovs_cnt + CW'(1);
        end
    end

    assign tick   = (ovs_cnt == OVS_MAX);
    assign at_t9  = tick && (tick_cnt == 4'd9);
    assign at_t15 = tick && (tick_cnt == 4'd15);
    assign vote   = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);
    assign enter  = (state_next != state);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (tick && !rx_s2 && armed) state_next = START;
            end
            START: begin
                if (at_t9 && vote) state_next = IDLE;
                else if (at_t15) state_next = DATA;
            end
            DATA: begin
                if (at_t15 && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (at_t9) state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        sample_bit = 1'b0;
        stop_done  = 1'b0;
        unique case (state)
            IDLE:  busy = 1'b0;
            START: busy = 1'b1;
            DATA:  sample_bit = at_t9;
            STOP:  stop_done = at_t9;
        endcase
    end

    assign stop_ok  = stop_done && vote;
    assign stop_bad = stop_done && !vote;
    assign load     = stop_ok && (!rx_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            s7       <= 1'b1;
            s8       <= 1'b1;
        end else begin
            if (enter) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            if (enter) begin
                bit_idx <= '0;
            end else if (state == DATA && at_t15) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (tick && tick_cnt == 4'd7) s7 <= rx_s2;
            if (tick && tick_cnt == 4'd8) s8 <= rx_s2;
        end
    end

    // After a framing error the line must be seen high before a new start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed <= 1'b1;
        end else if (stop_bad) begin
            armed <= 1'b0;
        end else if (state == IDLE && tick && rx_s2) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (sample_bit) begin
            shreg <= {vote, shreg[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= stop_ok && rx_valid && !rx_ready;
            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level reference model feeds
// expectation queues, an independent monitor checks DUT outputs.
module tb_uart_rx;

    localparam int CLK_FREQ = 768_000;
    localparam int BAUD     = 9600;
    localparam int NOM      = 8000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RxD = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] data_q[$];
    int         ferr_pend = 0;
    int         ovr_pend = 0;
    bit         held = 1'b0;
    bit         busy_seen = 1'b0;
    bit         prev_v = 1'b0;
    bit         prev_hs = 1'b0;
    logic [7:0] prev_d = '0;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RxD(RxD),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ready(input bit v);
        rx_ready = v;
        if (v) held = 1'b0;
    endtask

    // Frame-level model: outcome of one frame given the line and handshake.
    task automatic expect_frame(input logic [7:0] b, input bit ok);
        if (!ok) ferr_pend++;
        else if (held && !rx_ready) ovr_pend++;
        else begin
            data_q.push_back(b);
            held = !rx_ready;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit ok,
                             input int px100, input int nbits);
        logic [9:0] bits;
        bits = {ok, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            RxD = bits[i];
            cyc(((i + 1) * px100) / 100 - (i * px100) / 100);
        end
        RxD = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit ok,
                         input int px100, input int gap);
        expect_frame(b, ok);
        send_bits(b, ok, px100, 10);
        cyc(gap);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (busy) busy_seen = 1'b1;
            if (rx_valid && rx_ready) begin
                if (data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, data_q.pop_front()});
                end
            end
            if (frame_err) begin
                check("frame_err_expected", ferr_pend > 0, 1);
                if (ferr_pend > 0) ferr_pend--;
            end
            if (overrun) begin
                check("overrun_expected", ovr_pend > 0, 1);
                if (ovr_pend > 0) ovr_pend--;
            end
            if (prev_v && !prev_hs && rx_valid)
                check("rx_data_stable", rx_data, prev_d);
            prev_v = rx_valid;
            prev_hs = rx_valid && rx_ready;
            prev_d = rx_data;
        end
    end

    initial begin
        int pxs[3];
        bit got;
        logic [7:0] b;
        bit ok;
        pxs = '{8000, 7900, 8100};

        cyc(5);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        cyc(20);

        expect_frame(8'hA5, 1'b1);
        fork
            send_bits(8'hA5, 1'b1, NOM, 10);
            begin
                got = 1'b0;
                for (int i = 0; i < 1200 && !got; i++) begin
                    cyc(1);
                    if (rx_valid) got = 1'b1;
                end
                check("a5_valid_seen", got, 1);
                if (got) begin
                    check("a5_data", rx_data, 8'hA5);
                    cyc(1);
                    check("a5_valid_clear", rx_valid, 0);
                end
            end
        join
        cyc(40);

        set_ready(1'b0);
        frame(8'h3C, 1'b1, NOM, 30);
        frame(8'hC3, 1'b1, NOM, 30);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_kept", rx_data, 8'h3C);
        check("ovr_pulse_seen", ovr_pend, 0);
        set_ready(1'b1);
        cyc(5);
        check("ovr_drained", rx_valid, 0);

        frame(8'h55, 1'b0, NOM, 40);
        check("ferr_pulse_seen", ferr_pend, 0);
        check("ferr_no_valid", rx_valid, 0);

        busy_seen = 1'b0;
        RxD = 1'b0;
        cyc(15);
        RxD = 1'b1;
        cyc(200);
        check("glitch_busy_rose", busy_seen, 1);
        check("glitch_busy_fell", busy, 0);

        ferr_pend++;
        RxD = 1'b0;
        cyc(12 * 80);
        busy_seen = 1'b0;
        cyc(4 * 80);
        check("break_stays_idle", busy_seen, 0);
        check("break_ferr_seen", ferr_pend, 0);
        RxD = 1'b1;
        cyc(100);
        frame(8'h5A, 1'b1, NOM, 30);

        frame(8'h00, 1'b1, 8160, 0);
        frame(8'hFF, 1'b1, 8160, 40);
        frame(8'h00, 1'b1, 7840, 0);
        frame(8'hFF, 1'b1, 7840, 40);
        check("baud_skew_all_rx", data_q.size(), 0);

        send_bits(8'h81, 1'b1, NOM, 5);
        RxD = 1'b0;
        cyc(40);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        RxD = 1'b1;
        cyc(10);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_busy", busy, 0);
        held = 1'b0;
        rst_n = 1'b1;
        cyc(100);
        frame(8'h81, 1'b1, NOM, 40);
        check("post_rst_rx", data_q.size(), 0);

        repeat (30) begin
            b = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            set_ready($urandom_range(0, 2) != 0);
            frame(b, ok, pxs[$urandom_range(0, 2)],
                  ok ? $urandom_range(0, 30) : $urandom_range(20, 40));
        end

        set_ready(1'b1);
        cyc(50);
        check("end_data_q_empty", data_q.size(), 0);
        check("end_ferr_pending", ferr_pend, 0);
        check("end_ovr_pending", ovr_pend, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
